// File: rtl/datamem_param.sv
// Parametrised single-port data memory with byte enables, registered read and
// a sequential clear engine that initialises the array after reset or on request.
module datamem_param #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [DATA_W-1:0] INIT_WORD0 = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  write_enable,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     write_data,
    input  logic                  read_enable,
    output logic [DATA_W-1:0]     read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  access_dropped
);

    localparam int                NBYTES    = DATA_W / 8;
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Word 0 carries the configured init value; every other word clears to zero.
    function automatic logic [DATA_W-1:0] clear_word(input logic [ADDR_W-1:0] addr);
        if (addr == {ADDR_W{1'b0}}) begin
            return INIT_WORD0;
        end else begin
            return {DATA_W{1'b0}};
        end
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   clr_addr_r;
    logic [DATA_W-1:0]   read_data_r;
    logic                read_valid_r;
    logic                busy_r;
    logic                access_dropped_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [NBYTES-1:0]   mem_be_s;
    logic                req_s;

    assign req_s = read_enable | write_enable;

    // Array write port arbitration: the clear engine owns the port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = address;
        mem_wdata_s = write_data;
        mem_be_s    = byte_en;
        if (state_r == CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_r;
            mem_wdata_s = clear_word(clr_addr_r);
            mem_be_s    = {NBYTES{1'b1}};
        end else if (!clear_req && write_enable) begin
            mem_we_s    = 1'b1;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array with per-lane writes; deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (mem_we_s && mem_be_s[i]) begin
                mem_r[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
        end
    end

    // Control FSM: clear sequencing, registered read path and drop pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= CLEAR;
            clr_addr_r       <= {ADDR_W{1'b0}};
            busy_r           <= 1'b1;
            read_data_r      <= {DATA_W{1'b0}};
            read_valid_r     <= 1'b0;
            access_dropped_r <= 1'b0;
        end else begin
            read_valid_r     <= 1'b0;
            access_dropped_r <= 1'b0;
            case (state_r)
                CLEAR: begin
                    access_dropped_r <= req_s;
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r    <= READY;
                        busy_r     <= 1'b0;
                        clr_addr_r <= {ADDR_W{1'b0}};
                    end else begin
                        clr_addr_r <= clr_addr_r + ADDR_ONE;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state_r          <= CLEAR;
                        busy_r           <= 1'b1;
                        clr_addr_r       <= {ADDR_W{1'b0}};
                        access_dropped_r <= req_s;
                    end else if (read_enable) begin
                        // Nonblocking read of the array gives read-first behaviour.
                        read_data_r  <= mem_r[address];
                        read_valid_r <= 1'b1;
                    end else begin
                        read_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= CLEAR;
                    busy_r     <= 1'b1;
                    clr_addr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign read_data      = read_data_r;
    assign read_valid     = read_valid_r;
    assign busy           = busy_r;
    assign access_dropped = access_dropped_r;

endmodule

// File: tb/tb_datamem_param.sv
// Directed self-checking bench for datamem_param (16-bit words, 16-word array).
module tb_datamem_param;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic [3:0]  address;
    logic        write_enable;
    logic [1:0]  byte_en;
    logic [15:0] write_data;
    logic        read_enable;
    logic [15:0] read_data;
    logic        read_valid;
    logic        busy;
    logic        access_dropped;

    int total = 0;
    int bad   = 0;

    datamem_param #(.DATA_W(16), .ADDR_W(4), .INIT_WORD0(16'hA5C3)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .address(address),
        .write_enable(write_enable), .byte_en(byte_en), .write_data(write_data),
        .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
        .busy(busy), .access_dropped(access_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_req = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        byte_en = 2'b00; write_data = 16'h0000; address = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a);
        idle(); read_enable = 1'b1; address = a;
        step();
        idle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        idle(); write_enable = 1'b1; address = a; write_data = d; byte_en = be;
        step();
        idle();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle(); reset = 1'b0;
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
        total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", read_valid); end
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", read_data); end
        total++; if (access_dropped !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", access_dropped); end
        reset = 1'b1;
        count_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL rst_pass_len got=%0d exp=16", n); end
        rd(4'h0);
        total++; if (read_valid !== 1'b1 || read_data !== 16'hA5C3) begin
            bad++; $display("FAIL rd0 got=%h/%b exp=a5c3/1", read_data, read_valid); end
        for (int a = 1; a < 16; a++) begin
            rd(4'(a));
            total++; if (read_valid !== 1'b1 || read_data !== 16'h0000) begin
                bad++; $display("FAIL rd_cleared a=%0d got=%h/%b exp=0000/1", a, read_data, read_valid); end
        end
    endtask

    task automatic test_byte_enables();
        wr(4'h5, 16'h1234, 2'b11);
        wr(4'h5, 16'hFF00, 2'b01);
        rd(4'h5);
        total++; if (read_data !== 16'h1200) begin bad++; $display("FAIL be_low got=%h exp=1200", read_data); end
        wr(4'h5, 16'hAB00, 2'b10);
        rd(4'h5);
        total++; if (read_data !== 16'hAB00) begin bad++; $display("FAIL be_high got=%h exp=ab00", read_data); end
        wr(4'h5, 16'h5555, 2'b00);
        rd(4'h5);
        total++; if (read_data !== 16'hAB00) begin bad++; $display("FAIL be_none got=%h exp=ab00", read_data); end
        step();
        total++; if (read_valid !== 1'b0 || read_data !== 16'hAB00) begin
            bad++; $display("FAIL hold got=%h/%b exp=ab00/0", read_data, read_valid); end
    endtask

    task automatic test_read_first();
        idle(); address = 4'h7; write_enable = 1'b1; read_enable = 1'b1;
        write_data = 16'h00FF; byte_en = 2'b11;
        step();
        idle();
        total++; if (read_valid !== 1'b1 || read_data !== 16'h0000) begin
            bad++; $display("FAIL rf_same got=%h/%b exp=0000/1", read_data, read_valid); end
        rd(4'h7);
        total++; if (read_data !== 16'h00FF) begin bad++; $display("FAIL rf_after got=%h exp=00ff", read_data); end
    endtask

    task automatic test_back_to_back();
        idle(); read_enable = 1'b1; address = 4'h5;
        step();
        total++; if (read_valid !== 1'b1 || read_data !== 16'hAB00) begin
            bad++; $display("FAIL b2b_0 got=%h/%b exp=ab00/1", read_data, read_valid); end
        address = 4'h0;
        step();
        idle();
        total++; if (read_valid !== 1'b1 || read_data !== 16'hA5C3) begin
            bad++; $display("FAIL b2b_1 got=%h/%b exp=a5c3/1", read_data, read_valid); end
    endtask

    task automatic test_busy_drop();
        int n;
        idle(); clear_req = 1'b1;
        step();
        idle();
        total++; if (busy !== 1'b1 || access_dropped !== 1'b0) begin
            bad++; $display("FAIL clr_only got=%b/%b exp=1/0", busy, access_dropped); end
        for (int i = 0; i < 7; i++) step();
        rd(4'h0);
        total++; if (read_valid !== 1'b0 || access_dropped !== 1'b1) begin
            bad++; $display("FAIL busy_rd got=%b/%b exp=0/1", read_valid, access_dropped); end
        wr(4'h3, 16'h3333, 2'b11);
        total++; if (access_dropped !== 1'b1) begin bad++; $display("FAIL busy_wr got=%b exp=1", access_dropped); end
        count_busy(n);
        rd(4'h3);
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL busy_wr_lost got=%h exp=0000", read_data); end
    endtask

    task automatic test_clear_req();
        int n;
        wr(4'h9, 16'hBEEF, 2'b11);
        rd(4'h9);
        total++; if (read_data !== 16'hBEEF) begin bad++; $display("FAIL cr_pre got=%h exp=beef", read_data); end
        idle(); clear_req = 1'b1; write_enable = 1'b1; address = 4'h9;
        write_data = 16'h1234; byte_en = 2'b11;
        step();
        idle();
        total++; if (access_dropped !== 1'b1 || busy !== 1'b1 || read_valid !== 1'b0) begin
            bad++; $display("FAIL cr_drop got=%b/%b/%b exp=1/1/0", access_dropped, busy, read_valid); end
        count_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL cr_pass_len got=%0d exp=16", n); end
        rd(4'h9);
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL cr_a9 got=%h exp=0000", read_data); end
        rd(4'h0);
        total++; if (read_data !== 16'hA5C3) begin bad++; $display("FAIL cr_a0 got=%h exp=a5c3", read_data); end
    endtask

    task automatic test_reset_mid_pass();
        int n;
        idle(); clear_req = 1'b1;
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || read_data !== 16'h0000 || read_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rst got=%b/%h/%b exp=1/0000/0", busy, read_data, read_valid); end
        step(); step();
        reset = 1'b1;
        count_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL mid_pass_len got=%0d exp=16", n); end
        rd(4'h0);
        total++; if (read_data !== 16'hA5C3) begin bad++; $display("FAIL mid_a0 got=%h exp=a5c3", read_data); end
        rd(4'h7);
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL mid_a7 got=%h exp=0000", read_data); end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_byte_enables();
        test_read_first();
        test_back_to_back();
        test_busy_drop();
        test_clear_req();
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
- Parametrised successor to the single-port 16-bit data memory, used by the FP datapath's load/store stage.
- Adds generic width and depth, per-byte write enables, a registered read with a valid strobe, and a sequential clear engine.
- The clear engine replaces the single-cycle whole-array reset: it walks the array, writing INIT_WORD0 to address 0 and zero everywhere else.
- Accesses are refused and flagged while a clear is in progress.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8 and at least 8
ADDR_W, 16, address width; DEPTH = 2**ADDR_W words, minimum ADDR_W = 2
INIT_WORD0, 16'h0000, value written to word 0 by every clear pass; all other words are cleared to 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (asserted at 0)
clear_req  input  1  one-cycle request to re-run the clear pass; honoured only in READY
address  input  ADDR_W  word address for read/write
write_enable  input  1  write request
byte_en  input  DATA_W/8  byte lane enables; lane i covers bits 8i+7:8i
write_data  input  DATA_W  write data
read_enable  input  1  read request
read_data  output  DATA_W  registered read data
read_valid  output  1  high exactly one cycle after an accepted read
busy  output  1  high while the clear pass runs
access_dropped  output  1  one-cycle pulse when a read or write request is refused

Behaviour:
- Reset asserted (reset=0), asynchronously: state=CLEAR, clr_addr=0, busy=1, read_data=0, read_valid=0, access_dropped=0.
- The storage array is not asynchronously reset; it is initialised only by the clear pass.
- States: CLEAR and READY.
- CLEAR, each cycle after reset is released:
  - Writes mem[clr_addr] = (clr_addr==0 ? INIT_WORD0 : 0) to all lanes, then increments clr_addr.
  - On the cycle clr_addr == DEPTH-1 the last word is written; the next state is READY and busy goes to 0 on that same edge.
  - A full pass takes exactly DEPTH cycles after reset release.
  - clear_req is ignored in CLEAR; the pass is not restarted.
- READY, write: on write_enable=1, mem[address] lanes with byte_en[i]=1 take write_data lanes at the clock edge. Lanes with byte_en[i]=0 are unchanged. byte_en=0 is a legal no-op write.
- READY, read: on read_enable=1, read_data <= mem[address] at the edge and read_valid=1 for that one cycle. Latency is 1.
- read_data holds its last value while read_valid=0; it is never driven X.
- Same-cycle read and write to the same address: read-first. read_data returns the pre-write contents, and the write commits at the same edge.
- clear_req=1 in READY takes priority over any same-cycle access:
  - The access is dropped: no write, read_valid=0, access_dropped=1.
  - The next state is CLEAR with clr_addr=0 and busy=1.
- Any read_enable or write_enable while busy=1: no array change, read_valid=0, access_dropped=1 next cycle.
- access_dropped and read_valid are single-cycle registered pulses, both driven from the request cycle.
- Reset asserted mid-pass or mid-access: asynchronous return to the reset values above, and the clear restarts from address 0. A write in the reset-assertion cycle may be lost.
- address needs no bounds check, since all ADDR_W values are in range. clr_addr is ADDR_W wide and is not used past DEPTH-1.
- No X-propagation on read_data: the only reads are of cleared or written locations.

Test Plan:
All scenarios use DATA_W=16, ADDR_W=4, INIT_WORD0=16'hA5C3.
1. Release reset -> busy=1 for exactly 16 cycles, then 0. Read addr 0 -> 16'hA5C3 one cycle later with read_valid=1. Reading addrs 1..15 -> 16'h0000.
2. Write addr 5 data 16'h1234 with byte_en=2'b11, then write addr 5 data 16'hFF00 with byte_en=2'b01 -> read addr 5 = 16'h1200. Then byte_en=2'b10 with data 16'hAB00 -> reads 16'hAB00.
3. In one cycle, write addr 7 data 16'h00FF while reading addr 7 (prior contents 0) -> read_data=16'h0000, read_valid=1. The following read of addr 7 returns 16'h00FF.
4. Issue a read while busy=1 -> read_valid stays 0 and access_dropped pulses 1. Issue a write to addr 3 while busy -> addr 3 reads 0 after the clear pass.
5. With addr 9 holding 16'hBEEF, assert clear_req together with a write to addr 9 -> access_dropped=1 and busy=1 for 16 cycles. Afterwards addr 9 = 0 and addr 0 = 16'hA5C3.
6. Drop reset to 0 at cycle 6 of a clear pass -> busy stays 1 and the pass restarts. busy falls exactly 16 cycles after reset is released again.
